channel_readout_sequencer: RTL

//  Frame-level readout scheduler for the spectrogram extractor.
//  On each frame tick (ovf) it walks the enabled channel slots (slot 0 = RTC, 1..15 = filter channels),

---
 rtl/spectro_pkg.sv | 19 +
 rtl/piso_shift.sv | 28 ++
 rtl/channel_readout_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spectro_pkg.sv
// Shared definitions for the spectrogram readout path: FSM state codes,
// the frame sync byte and the default slot count.
package spectro_pkg;

  localparam int NUM_SLOTS_DEFAULT = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SELECT = 3'd1;
  localparam state_t ST_LOAD   = 3'd2;
  localparam state_t ST_SHIFT  = 3'd3;
  localparam state_t ST_NEXT   = 3'd4;
  localparam state_t ST_CLEAR  = 3'd5;
  localparam state_t ST_HEADER = 3'd6;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out register, MSB first. Load has priority over shift;
// vacated LSBs fill with zero.
module piso_shift #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/channel_readout_sequencer.sv
// Frame readout scheduler: walks enabled slots, loads each mux value into a PISO
// and streams it out serially. Optional FRAME_HEADER_EN sends 0xA5 before the slots.
module channel_readout_sequencer
  import spectro_pkg::*;
#(
  parameter int NUM_SLOTS  = NUM_SLOTS_DEFAULT,
  parameter int DATA_W     = 12,
  parameter int SETTLE_CYC = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ovf,
  input  logic [NUM_SLOTS-1:0]         chan_mask,
  input  logic [DATA_W-1:0]            data_in,
  output logic [$clog2(NUM_SLOTS)-1:0] sel,
  output logic                         load,
  output logic                         sout,
  output logic                         sout_valid,
  input  logic                         sout_ready,
  output logic                         frame_start,
  output logic                         frame_done,
  output logic                         acc_clear,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         overrun_clr,
  output logic [STATE_W-1:0]           dbg_state_o
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam int BW = $clog2(DATA_W);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_W - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic                 overrun_q;
  logic                 piso_load, piso_shift_en, piso_msb;
  logic [DATA_W-1:0]    piso_word;
  logic [IW:0]          hit;

  // Lowest set bit of m at position >= lo; MSB of the result flags a hit.
  function automatic logic [IW:0] find_from(input logic [NUM_SLOTS-1:0] m, input int lo);
    logic [IW:0] r;
    r = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, i[IW-1:0]};
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      bitcnt_q  <= '0;
      settle_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      bitcnt_q <= bitcnt_d;
      settle_q <= settle_d;
      // A dropped tick outranks a simultaneous clear.
      if (ovf && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      else if (overrun_clr)             overrun_q <= 1'b0;
    end
  end

  // Serial handshake: a bit transfers on a cycle with sout_valid and sout_ready
  // both high; until then sout_valid stays high and sout does not change.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    mask_d        = mask_q;
    bitcnt_d      = bitcnt_q;
    settle_d      = settle_q;
    piso_load     = 1'b0;
    piso_shift_en = 1'b0;
    piso_word     = data_in;
    hit           = '0;
    case (state_q)
      ST_IDLE: begin
        if (ovf) begin
          hit      = find_from(chan_mask, 0);
          mask_d   = chan_mask;
          idx_d    = hit[IW-1:0];
          settle_d = '0;
`ifdef FRAME_HEADER_EN
          state_d   = ST_HEADER;
          piso_load = 1'b1;
          piso_word = DATA_W'(SYNC_BYTE) << (DATA_W - 8);
          bitcnt_d  = BW'(7);
`else
          state_d = hit[IW] ? ST_SELECT : ST_CLEAR;
`endif
        end
      end
`ifdef FRAME_HEADER_EN
      ST_HEADER: begin
        if (sout_ready) begin
          piso_shift_en = 1'b1;
          bitcnt_d      = bitcnt_q - 1'b1;
          if (bitcnt_q == '0) state_d = (mask_q != '0) ? ST_SELECT : ST_CLEAR;
        end
      end
`endif
      ST_SELECT: begin
        if (settle_q == SETTLE_LAST) state_d = ST_LOAD;
        else settle_d = settle_q + 1'b1;
      end
      ST_LOAD: begin
        piso_load = 1'b1;
        bitcnt_d  = BIT_LAST;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sout_ready) begin
          piso_shift_en = 1'b1;
          bitcnt_d      = bitcnt_q - 1'b1;
          if (bitcnt_q == '0) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        hit = find_from(mask_q, int'(idx_q) + 1);
        if (hit[IW]) begin
          idx_d    = hit[IW-1:0];
          settle_d = '0;
          state_d  = ST_SELECT;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel         = '0;
    load        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    acc_clear   = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:   frame_start = ovf;
`ifdef FRAME_HEADER_EN
      ST_HEADER: sout_valid = 1'b1;
`endif
      ST_SELECT: sel = idx_q;
      ST_LOAD: begin
        sel  = idx_q;
        load = 1'b1;
      end
      ST_SHIFT: begin
        sel        = idx_q;
        sout_valid = 1'b1;
      end
      ST_NEXT:   sel = idx_q;
      ST_CLEAR: begin
        sel        = idx_q;
        frame_done = 1'b1;
        acc_clear  = 1'b1;
      end
      default: ;
    endcase
    sout = sout_valid & piso_msb;
  end

  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

  piso_shift #(.W(DATA_W)) u_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (piso_load),
    .data_i  (piso_word),
    .shift_i (piso_shift_en),
    .msb_o   (piso_msb)
  );

endmodule
